// File: rtl/oq_stats_counters.sv
// Per-queue stored/removed/dropped/in-queue packet and byte counters with a 1-cycle read port.
// Build option: define OQ_STATS_SATURATE_EN to make the cumulative counters saturate instead of wrap.
module oq_stats_counters #(
  parameter int NUM_QUEUES = 5,
  parameter int CNTR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int IDX_WIDTH  = 7
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,
  input  logic [NUM_QUEUES-1:0]           stored_vld,
  input  logic [LEN_WIDTH-1:0]            stored_len,
  input  logic [NUM_QUEUES-1:0]           dropped_vld,
  input  logic [LEN_WIDTH-1:0]            dropped_len,
  input  logic [NUM_QUEUES-1:0]           removed_vld,
  input  logic [NUM_QUEUES*LEN_WIDTH-1:0] removed_len,
  input  logic                            clr,
  input  logic                            rd_req,
  input  logic [IDX_WIDTH-1:0]            rd_idx,
  output logic                            rd_ack,
  output logic [CNTR_WIDTH-1:0]           rd_data,
  output logic                            rd_err,
  output logic [NUM_QUEUES-1:0]           underflow
);
  localparam int NUM_CNTRS = 8 * NUM_QUEUES;
  localparam logic [CNTR_WIDTH-1:0] CNTR_MAX = {CNTR_WIDTH{1'b1}};
  localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = CNTR_WIDTH'(1);

  function automatic logic [CNTR_WIDTH-1:0] f_cum(input logic [CNTR_WIDTH-1:0] cur,
                                                  input logic [CNTR_WIDTH-1:0] inc);
`ifdef OQ_STATS_SATURATE_EN
    logic [CNTR_WIDTH:0] sum;
    sum   = {1'b0, cur} + {1'b0, inc};
    f_cum = sum[CNTR_WIDTH] ? CNTR_MAX : sum[CNTR_WIDTH-1:0];
`else
    f_cum = cur + inc;
`endif
  endfunction

  // Returns {underflow, value}; the two extra bits catch both going negative and overflowing.
  function automatic logic [CNTR_WIDTH:0] f_occ(input logic [CNTR_WIDTH-1:0] cur,
                                                input logic [CNTR_WIDTH-1:0] add,
                                                input logic [CNTR_WIDTH-1:0] sub);
    logic [CNTR_WIDTH+1:0] net;
    net = {2'b00, cur} + {2'b00, add} - {2'b00, sub};
    if (net[CNTR_WIDTH+1])    f_occ = {1'b1, {CNTR_WIDTH{1'b0}}};
    else if (net[CNTR_WIDTH]) f_occ = {1'b0, CNTR_MAX};
    else                      f_occ = {1'b0, net[CNTR_WIDTH-1:0]};
  endfunction

  logic                            r_clr_d;
  logic [NUM_QUEUES-1:0]           r_stored_vld, r_dropped_vld, r_removed_vld;
  logic [LEN_WIDTH-1:0]            r_stored_len, r_dropped_len;
  logic [NUM_QUEUES*LEN_WIDTH-1:0] r_removed_len;
  logic [CNTR_WIDTH-1:0]           r_cnt [NUM_CNTRS];
  logic [NUM_QUEUES-1:0]           r_underflow;
  logic                            r_rd_ack, r_rd_err;
  logic [CNTR_WIDTH-1:0]           r_rd_data;

  logic [CNTR_WIDTH-1:0] w_cnt_nxt [NUM_CNTRS];
  logic [NUM_QUEUES-1:0] w_uf_nxt;
  logic [CNTR_WIDTH-1:0] w_st_len, w_dr_len, w_rd_val;
  logic                  w_idx_ok;

  assign w_st_len = CNTR_WIDTH'(r_stored_len);
  assign w_dr_len = CNTR_WIDTH'(r_dropped_len);

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_q
    logic [CNTR_WIDTH-1:0] w_rm_len, w_st_add, w_rm_sub;
    logic [CNTR_WIDTH:0]   w_pkt_occ, w_byte_occ;

    assign w_rm_len   = CNTR_WIDTH'(r_removed_len[g*LEN_WIDTH +: LEN_WIDTH]);
    assign w_st_add   = r_stored_vld[g]  ? w_st_len : '0;
    assign w_rm_sub   = r_removed_vld[g] ? w_rm_len : '0;
    assign w_pkt_occ  = f_occ(r_cnt[g*8+6], CNTR_WIDTH'(r_stored_vld[g]), CNTR_WIDTH'(r_removed_vld[g]));
    assign w_byte_occ = f_occ(r_cnt[g*8+7], w_st_add, w_rm_sub);

    assign w_cnt_nxt[g*8+0] = r_stored_vld[g]  ? f_cum(r_cnt[g*8+0], CNTR_ONE) : r_cnt[g*8+0];
    assign w_cnt_nxt[g*8+1] = r_stored_vld[g]  ? f_cum(r_cnt[g*8+1], w_st_len) : r_cnt[g*8+1];
    assign w_cnt_nxt[g*8+2] = r_removed_vld[g] ? f_cum(r_cnt[g*8+2], CNTR_ONE) : r_cnt[g*8+2];
    assign w_cnt_nxt[g*8+3] = r_removed_vld[g] ? f_cum(r_cnt[g*8+3], w_rm_len) : r_cnt[g*8+3];
    assign w_cnt_nxt[g*8+4] = r_dropped_vld[g] ? f_cum(r_cnt[g*8+4], CNTR_ONE) : r_cnt[g*8+4];
    assign w_cnt_nxt[g*8+5] = r_dropped_vld[g] ? f_cum(r_cnt[g*8+5], w_dr_len) : r_cnt[g*8+5];
    assign w_cnt_nxt[g*8+6] = w_pkt_occ[CNTR_WIDTH-1:0];
    assign w_cnt_nxt[g*8+7] = w_byte_occ[CNTR_WIDTH-1:0];
    assign w_uf_nxt[g]      = r_underflow[g] | w_pkt_occ[CNTR_WIDTH] | w_byte_occ[CNTR_WIDTH];
  end

  // Stage 1 is held empty for the clr cycle and the one after it, so those events never land.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_clr_d       <= 1'b0;
      r_stored_vld  <= '0;
      r_dropped_vld <= '0;
      r_removed_vld <= '0;
      r_stored_len  <= '0;
      r_dropped_len <= '0;
      r_removed_len <= '0;
    end else begin
      r_clr_d <= clr;
      if (clr || r_clr_d) begin
        r_stored_vld  <= '0;
        r_dropped_vld <= '0;
        r_removed_vld <= '0;
        r_stored_len  <= '0;
        r_dropped_len <= '0;
        r_removed_len <= '0;
      end else begin
        r_stored_vld  <= stored_vld;
        r_dropped_vld <= dropped_vld;
        r_removed_vld <= removed_vld;
        r_stored_len  <= stored_len;
        r_dropped_len <= dropped_len;
        r_removed_len <= removed_len;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      for (int i = 0; i < NUM_CNTRS; i++) r_cnt[i] <= '0;
      r_underflow <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CNTRS; i++) r_cnt[i] <= '0;
      r_underflow <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_underflow <= w_uf_nxt;
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_CNTRS; i++)
      if (rd_idx == IDX_WIDTH'(i)) w_rd_val = r_cnt[i];
  end
  assign w_idx_ok = 32'(rd_idx) < NUM_CNTRS;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_rd_ack  <= 1'b0;
      r_rd_err  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack  <= rd_req;
      r_rd_err  <= rd_req && !w_idx_ok;
      r_rd_data <= rd_req ? w_rd_val : '0;
    end
  end

  assign rd_ack    = r_rd_ack;
  assign rd_err    = r_rd_err;
  assign rd_data   = r_rd_data;
  assign underflow = r_underflow;
endmodule

// File: tb/tb_oq_stats_counters.sv
// Self-checking bench for oq_stats_counters: directed scenarios plus random traffic against a counter model.
module tb_oq_stats_counters;
  localparam int NQ = 5;
  localparam int CW = 20;
  localparam int LW = 16;
  localparam int IW = 7;
  localparam int NC = 8 * NQ;
  localparam longint MAXV = (longint'(1) << CW) - 1;

  logic            axi_aclk = 1'b0;
  logic            axi_resetn = 1'b0;
  logic [NQ-1:0]   stored_vld = '0, dropped_vld = '0, removed_vld = '0;
  logic [LW-1:0]   stored_len = '0, dropped_len = '0;
  logic [NQ*LW-1:0] removed_len = '0;
  logic            clr = 1'b0, rd_req = 1'b0;
  logic [IW-1:0]   rd_idx = '0;
  logic            rd_ack, rd_err;
  logic [CW-1:0]   rd_data;
  logic [NQ-1:0]   underflow;

  int n_checks = 0;
  int n_fail = 0;

  longint    m_cnt [NC];
  bit [NQ-1:0] m_uf;
  bit        m_skip;

  oq_stats_counters #(.NUM_QUEUES(NQ), .CNTR_WIDTH(CW), .LEN_WIDTH(LW), .IDX_WIDTH(IW)) dut (
    .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
    .stored_vld(stored_vld), .stored_len(stored_len),
    .dropped_vld(dropped_vld), .dropped_len(dropped_len),
    .removed_vld(removed_vld), .removed_len(removed_len),
    .clr(clr), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err), .underflow(underflow)
  );

  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  function automatic longint cum(input longint cur, input longint inc);
    longint s;
    s = cur + inc;
`ifdef OQ_STATS_SATURATE_EN
    return (s > MAXV) ? MAXV : s;
`else
    return s % (MAXV + 1);
`endif
  endfunction

  task automatic m_clear();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_uf = '0;
  endtask

  task automatic m_apply(input logic [NQ-1:0] sv, input longint sl, input logic [NQ-1:0] dv,
                         input longint dl, input logic [NQ-1:0] rv, input logic [NQ*LW-1:0] rl);
    for (int q = 0; q < NQ; q++) begin
      longint rlen, p, b;
      rlen = longint'(rl[q*LW +: LW]);
      if (sv[q]) begin m_cnt[q*8+0] = cum(m_cnt[q*8+0], 1); m_cnt[q*8+1] = cum(m_cnt[q*8+1], sl);   end
      if (rv[q]) begin m_cnt[q*8+2] = cum(m_cnt[q*8+2], 1); m_cnt[q*8+3] = cum(m_cnt[q*8+3], rlen); end
      if (dv[q]) begin m_cnt[q*8+4] = cum(m_cnt[q*8+4], 1); m_cnt[q*8+5] = cum(m_cnt[q*8+5], dl);   end
      p = m_cnt[q*8+6] + (sv[q] ? 1 : 0) - (rv[q] ? 1 : 0);
      b = m_cnt[q*8+7] + (sv[q] ? sl : 0) - (rv[q] ? rlen : 0);
      if (p < 0 || b < 0) m_uf[q] = 1'b1;
      m_cnt[q*8+6] = (p < 0) ? 0 : (p > MAXV) ? MAXV : p;
      m_cnt[q*8+7] = (b < 0) ? 0 : (b > MAXV) ? MAXV : b;
    end
  endtask

  // One cycle of event stimulus; the model sees events the design is expected to keep.
  task automatic ev(input logic [NQ-1:0] sv, input int unsigned sl, input logic [NQ-1:0] dv,
                    input int unsigned dl, input logic [NQ-1:0] rv, input logic [NQ*LW-1:0] rl, input bit c);
    stored_vld = sv; stored_len = LW'(sl);
    dropped_vld = dv; dropped_len = LW'(dl);
    removed_vld = rv; removed_len = rl;
    clr = c;
    if (c) begin m_clear(); m_skip = 1'b1; end
    else if (m_skip) m_skip = 1'b0;
    else m_apply(sv, longint'(sl), dv, longint'(dl), rv, rl);
    @(negedge axi_aclk);
  endtask

  task automatic idle(input int n);
    repeat (n) ev('0, 0, '0, 0, '0, '0, 1'b0);
  endtask

  task automatic clear_all();
    ev('0, 0, '0, 0, '0, '0, 1'b1);
    idle(1);
  endtask

  // Back-to-back reads of every index plus two out-of-range ones.
  task automatic read_all(input string tag);
    int prev;
    longint exp_d;
    idle(2);
    n_checks++;
    if (underflow !== m_uf) begin
      n_fail++; $display("FAIL %s underflow got=%b exp=%b", tag, underflow, m_uf);
    end
    prev = 0;
    for (int i = 0; i < 43; i++) begin
      if (i > 0) begin
        exp_d = (prev < NC) ? m_cnt[prev] : 0;
        n_checks += 3;
        if (rd_ack !== 1'b1) begin
          n_fail++; $display("FAIL %s rd_ack idx=%0d got=%b exp=1", tag, prev, rd_ack);
        end
        if (rd_data !== CW'(exp_d)) begin
          n_fail++; $display("FAIL %s rd_data idx=%0d got=%0d exp=%0d", tag, prev, rd_data, exp_d);
        end
        if (rd_err !== (prev >= NC)) begin
          n_fail++; $display("FAIL %s rd_err idx=%0d got=%b exp=%b", tag, prev, rd_err, prev >= NC);
        end
      end
      if (i < 42) begin
        prev = (i < NC) ? i : (i == NC) ? NC : 127;
        rd_req = 1'b1; rd_idx = IW'(prev);
      end else rd_req = 1'b0;
      @(negedge axi_aclk);
    end
    n_checks++;
    if (rd_ack !== 1'b0) begin
      n_fail++; $display("FAIL %s rd_ack_drop got=%b exp=0", tag, rd_ack);
    end
  endtask

  task automatic test_reset();
    axi_resetn = 1'b0; m_clear(); m_skip = 1'b0;
    repeat (2) @(negedge axi_aclk);
    n_checks += 4;
    if (rd_ack !== 1'b0)    begin n_fail++; $display("FAIL reset rd_ack got=%b exp=0", rd_ack); end
    if (rd_data !== '0)     begin n_fail++; $display("FAIL reset rd_data got=%0d exp=0", rd_data); end
    if (rd_err !== 1'b0)    begin n_fail++; $display("FAIL reset rd_err got=%b exp=0", rd_err); end
    if (underflow !== '0)   begin n_fail++; $display("FAIL reset underflow got=%b exp=0", underflow); end
    axi_resetn = 1'b1;
    read_all("reset");
  endtask

  task automatic test_multicast();
    clear_all();
    ev(5'b10001, 64, '0, 0, '0, '0, 1'b0);
    ev('0, 0, '0, 0, 5'b00001, 80'(64), 1'b0);
    read_all("multicast");
  endtask

  task automatic test_simul_store_remove();
    clear_all();
    ev(5'b00100, 100, '0, 0, '0, '0, 1'b0);
    ev(5'b00100, 100, '0, 0, 5'b00100, 80'(100) << 32, 1'b0);
    read_all("simul");
  endtask

  task automatic test_underflow();
    clear_all();
    ev('0, 0, '0, 0, 5'b00010, 80'(60) << 16, 1'b0);
    idle(2);
    n_checks++;
    if (underflow !== 5'b00010) begin
      n_fail++; $display("FAIL underflow_flag got=%b exp=00010", underflow);
    end
    read_all("underflow");
    clear_all();
    read_all("underflow_clr");
  endtask

  task automatic test_clr_drop();
    clear_all();
    ev(5'b00001, 300, '0, 0, '0, '0, 1'b0);
    ev('0, 0, 5'b01000, 1500, '0, '0, 1'b1);
    ev(5'b00010, 200, 5'b01000, 1500, '0, '0, 1'b0);
    ev('0, 0, 5'b01000, 700, '0, '0, 1'b0);
    read_all("clr_drop");
  endtask

  task automatic test_latency();
    longint old_v;
    logic [CW-1:0] exp_v [3];
    old_v = m_cnt[1];
    rd_req = 1'b1; rd_idx = IW'(1);
    ev(5'b00001, 10, '0, 0, '0, '0, 1'b0);
    exp_v[0] = CW'(old_v); exp_v[1] = CW'(old_v); exp_v[2] = CW'(m_cnt[1]);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) idle(1);
      n_checks++;
      if (rd_data !== exp_v[c]) begin
        n_fail++; $display("FAIL latency cycle=%0d got=%0d exp=%0d", c, rd_data, exp_v[c]);
      end
    end
    rd_req = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_midop();
    ev(5'b00001, 7, '0, 0, '0, '0, 1'b0);
    stored_vld = 5'b00001; stored_len = 16'd9; rd_req = 1'b1; rd_idx = '0;
    #2 axi_resetn = 1'b0;
    @(posedge axi_aclk); #1;
    n_checks += 2;
    if (rd_ack !== 1'b0)  begin n_fail++; $display("FAIL midop rd_ack got=%b exp=0", rd_ack); end
    if (rd_data !== '0)   begin n_fail++; $display("FAIL midop rd_data got=%0d exp=0", rd_data); end
    stored_vld = '0; stored_len = '0; rd_req = 1'b0;
    @(negedge axi_aclk);
    axi_resetn = 1'b1; m_clear(); m_skip = 1'b0;
    @(negedge axi_aclk);
    n_checks++;
    if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL midop rd_ack_after got=%b exp=0", rd_ack); end
    read_all("midop");
  endtask

  task automatic test_saturate();
    logic [CW-1:0] exp_bs;
`ifdef OQ_STATS_SATURATE_EN
    exp_bs = 20'hFFFFF;
`else
    exp_bs = 20'd54;
`endif
    clear_all();
    repeat (16) ev(5'b00001, 65535, '0, 0, 5'b00001, 80'(65535), 1'b0);
    ev(5'b00001, 6, '0, 0, 5'b00001, 80'(6), 1'b0);
    ev(5'b00001, 64, '0, 0, '0, '0, 1'b0);
    read_all("saturate");
    rd_req = 1'b1; rd_idx = IW'(1);
    @(negedge axi_aclk);
    rd_idx = IW'(3);
    n_checks++;
    if (rd_data !== exp_bs) begin n_fail++; $display("FAIL sat bytes_stored got=%0d exp=%0d", rd_data, exp_bs); end
    @(negedge axi_aclk);
    rd_req = 1'b0;
    n_checks++;
    if (rd_data !== 20'd1048566) begin n_fail++; $display("FAIL sat bytes_removed got=%0d exp=1048566", rd_data); end
    idle(1);
  endtask

  task automatic test_random();
    logic [NQ*LW-1:0] rl;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 80; c++) begin
        for (int q = 0; q < NQ; q++) rl[q*LW +: LW] = LW'($urandom_range(1, 1500));
        ev(NQ'($urandom) & NQ'($urandom), $urandom_range(1, 1500),
           NQ'($urandom) & NQ'($urandom), $urandom_range(1, 1500),
           NQ'($urandom) & NQ'($urandom), rl, $urandom_range(0, 39) == 0);
      end
      read_all("random");
    end
  endtask

  initial begin
    m_clear(); m_skip = 1'b0;
    test_reset();
    test_multicast();
    test_simul_store_remove();
    test_underflow();
    test_clr_drop();
    test_latency();
    test_reset_midop();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
